// File: rtl/rcv_link_pkg.sv
// rcv_link_pkg: shared types, constants and helpers for the receive-link deserializer.
// RCV_PARITY_EN selects 17-bit words (16 data + even parity) instead of 16-bit words.
package rcv_link_pkg;
  typedef enum logic [0:0] {HUNT = 1'b0, SHIFT = 1'b1} wst_e;
  typedef enum logic [0:0] {WAIT_HDR = 1'b0, SAMPLES = 1'b1} pst_e;
  localparam int WORD_W = 16;
`ifdef RCV_PARITY_EN
  localparam int WORD_L = WORD_W + 1;
`else
  localparam int WORD_L = WORD_W;
`endif
  localparam int DEF_MAX_LEN = 4095;
  localparam logic [3:0] DEF_HDR_TAG = 4'hA;
  localparam int TAG_MSB = 15;
  localparam int TAG_LSB = 12;
  localparam int LEN_MSB = 11;
  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction
endpackage

// File: rtl/rcv_packet_deser_if.sv
// rcv_packet_deser_if: serial link inputs plus the parsed sample stream and diagnostics.
interface rcv_packet_deser_if;
  import rcv_link_pkg::*;
  logic              i_fs;
  logic              i_d;
  logic              i_clr_cnt;
  logic [WORD_W-1:0] o_data;
  logic              o_vld;
  logic              o_hdr_vld;
  logic [LEN_MSB:0]  o_pkt_len;
  logic              o_pkt_done;
  logic              o_in_pkt;
  logic [7:0]        o_par_err_cnt;
  logic [7:0]        o_frm_err_cnt;
  logic [7:0]        o_hdr_err_cnt;
  modport master (
    output i_fs, i_d, i_clr_cnt,
    input  o_data, o_vld, o_hdr_vld, o_pkt_len, o_pkt_done, o_in_pkt,
           o_par_err_cnt, o_frm_err_cnt, o_hdr_err_cnt
  );
  modport slave (
    input  i_fs, i_d, i_clr_cnt,
    output o_data, o_vld, o_hdr_vld, o_pkt_len, o_pkt_done, o_in_pkt,
           o_par_err_cnt, o_frm_err_cnt, o_hdr_err_cnt
  );
endinterface

// File: rtl/rcv_word_shifter.sv
// rcv_word_shifter: frames i_d into words on i_fs, flags parity and early-sync errors.
// Word results are combinational on the completing cycle; the top registers them.
module rcv_word_shifter
  import rcv_link_pkg::*;
(
  input  logic              rst_n,
  input  logic              rcv_clk,
  input  logic              fs_i,
  input  logic              d_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ok_o,
  output logic              word_par_err_o,
  output logic              word_frm_err_o
);
  wst_e st_q, st_d;
  logic [WORD_L-2:0] sr_q;
  logic [WORD_L-1:0] full;
  logic [4:0] cnt_q, cnt_d;
  logic done, par_bad;
  // Stale bits need no clearing: a complete word shifts them all out.
  always_comb begin
    full = {sr_q, d_i};
    done = (st_q == SHIFT) && (cnt_q == 5'(WORD_L - 1));
`ifdef RCV_PARITY_EN
    par_bad = ^full;
`else
    par_bad = 1'b0;
`endif
    word_o = full[WORD_L-1 -: WORD_W];
    word_ok_o = done && !par_bad;
    word_par_err_o = done && par_bad;
    word_frm_err_o = (st_q == SHIFT) && fs_i && !done;
    st_d = fs_i ? SHIFT : (done ? HUNT : st_q);
    cnt_d = fs_i ? 5'd1 : cnt_q + 5'd1;
  end
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= HUNT;
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      sr_q <= full[WORD_L-2:0];
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rcv_packet_deser.sv
// rcv_packet_deser: packet parser (header + N samples) and saturating error counters.
// Build with RCV_PARITY_EN for parity-protected 17-bit words.
module rcv_packet_deser
  import rcv_link_pkg::*;
#(
  parameter int         MAX_LEN = DEF_MAX_LEN,
  parameter logic [3:0] HDR_TAG = DEF_HDR_TAG
) (
  input logic rst_n,
  input logic rcv_clk,
  rcv_packet_deser_if.slave lnk
);
  logic [WORD_W-1:0] word, data_q, data_d;
  logic word_ok, word_par_err, word_frm_err, hdr_good;
  logic [LEN_MSB:0] len_f, len_q, len_d, rem_q, rem_d;
  logic vld_q, vld_d, hdr_vld_q, hdr_vld_d, done_q, done_d;
  logic [7:0] par_q, par_d, frm_q, frm_d, hdr_q, hdr_d;
  pst_e pst_q, pst_d;
  rcv_word_shifter u_shift (
    .rst_n(rst_n),
    .rcv_clk(rcv_clk),
    .fs_i(lnk.i_fs),
    .d_i(lnk.i_d),
    .word_o(word),
    .word_ok_o(word_ok),
    .word_par_err_o(word_par_err),
    .word_frm_err_o(word_frm_err)
  );
  always_comb begin
    len_f = word[LEN_MSB:0];
    hdr_good = (word[TAG_MSB:TAG_LSB] == HDR_TAG) && (len_f != '0) && (int'(len_f) <= MAX_LEN);
    pst_d = pst_q;
    data_d = data_q;
    len_d = len_q;
    rem_d = rem_q;
    vld_d = 1'b0;
    hdr_vld_d = 1'b0;
    done_d = 1'b0;
    par_d = word_par_err ? sat_inc8(par_q) : par_q;
    frm_d = word_frm_err ? sat_inc8(frm_q) : frm_q;
    hdr_d = hdr_q;
    if (word_frm_err) pst_d = WAIT_HDR;
    if (word_ok && pst_q == WAIT_HDR) begin
      if (hdr_good) begin
        len_d = len_f;
        rem_d = len_f;
        hdr_vld_d = 1'b1;
        pst_d = SAMPLES;
      end else begin
        hdr_d = sat_inc8(hdr_q);
      end
    end else if (word_ok) begin
      data_d = word;
      vld_d = 1'b1;
      rem_d = rem_q - 1'b1;
      done_d = (rem_q == 12'd1);
      pst_d = done_d ? WAIT_HDR : SAMPLES;
    end
    if (lnk.i_clr_cnt) begin
      par_d = '0;
      frm_d = '0;
      hdr_d = '0;
    end
  end
  always_ff @(posedge rcv_clk or negedge rst_n) begin
    if (!rst_n) begin
      pst_q <= WAIT_HDR;
      data_q <= '0;
      len_q <= '0;
      rem_q <= '0;
      vld_q <= 1'b0;
      hdr_vld_q <= 1'b0;
      done_q <= 1'b0;
      par_q <= '0;
      frm_q <= '0;
      hdr_q <= '0;
    end else begin
      pst_q <= pst_d;
      data_q <= data_d;
      len_q <= len_d;
      rem_q <= rem_d;
      vld_q <= vld_d;
      hdr_vld_q <= hdr_vld_d;
      done_q <= done_d;
      par_q <= par_d;
      frm_q <= frm_d;
      hdr_q <= hdr_d;
    end
  end
  assign lnk.o_data = data_q;
  assign lnk.o_vld = vld_q;
  assign lnk.o_hdr_vld = hdr_vld_q;
  assign lnk.o_pkt_len = len_q;
  assign lnk.o_pkt_done = done_q;
  assign lnk.o_in_pkt = (pst_q == SAMPLES);
  assign lnk.o_par_err_cnt = par_q;
  assign lnk.o_frm_err_cnt = frm_q;
  assign lnk.o_hdr_err_cnt = hdr_q;
endmodule

// File: doc/rcv_packet_deser.md
Name: rcv_packet_deser

Overview:
- Front-end deserializer for the receiver serial link in the rcv_clk domain, upstream of ADC packing and the scan buffer.
- Shifts i_d into 16-bit words framed by i_fs and checks per-word parity.
- Parses each packet (header word + N sample words); only sample words are emitted as a valid stream.
- Keeps saturating error counters for link diagnostics.

Parameters:
- WORD_W, 16, data bits per word, MSB first.
- MAX_LEN, 4095, largest legal sample count in a header; longer headers are rejected.
- HDR_TAG, 4'hA, required value of header bits [15:12].

Ports:
- rst_n  in  1  asynchronous, active-low reset
- rcv_clk  in  1  receive clock; all logic on the rising edge
- i_fs  in  1  frame sync; high during the first (MSB) bit of every word
- i_d  in  1  serial data
- i_clr_cnt  in  1  synchronous clear of all error counters
- o_data  out  16  last accepted sample word
- o_vld  out  1  one-cycle strobe, o_data valid
- o_hdr_vld  out  1  one-cycle strobe, valid header accepted
- o_pkt_len  out  12  length field of the last accepted header
- o_pkt_done  out  1  one-cycle strobe with the last sample of a packet
- o_in_pkt  out  1  high while sample words are expected
- o_par_err_cnt  out  8  parity error count, saturates at 255
- o_frm_err_cnt  out  8  framing error count, saturates at 255
- o_hdr_err_cnt  out  8  bad-header count, saturates at 255

Behaviour:
- Reset: all outputs and counters 0; word FSM = HUNT; packet FSM = WAIT_HDR.
- Word length: L = WORD_W+1 bits (data followed by an even-parity bit) with RCV_PARITY_EN; L = WORD_W otherwise.

Word FSM:
- HUNT: ignore i_d until i_fs=1. On that cycle, load i_d as the MSB, set bit_cnt=1, go to SHIFT.
- SHIFT: shift i_d in and increment bit_cnt. The cycle that samples bit L-1 completes the word and returns to HUNT.
- i_fs=1 during SHIFT with bit_cnt!=0 is an early sync:
  - current word discarded; frm_err_cnt +1;
  - that cycle's bit is taken as the MSB of a new word (bit_cnt=1).
- i_fs=1 on the same cycle a word completes: the word completes normally and i_fs starts the next word (back-to-back words, no gap).
- Gaps of any length between words are legal and stay in HUNT.

Word completion:
- Word evaluated on the completing cycle; result registered, so outputs appear 1 cycle after the last bit is sampled.
- Parity mismatch (XOR of all L bits != 0): par_err_cnt +1, word dropped, packet FSM unaffected.

Packet FSM:
- WAIT_HDR, good word with [15:12]==HDR_TAG and 1 <= [11:0] <= MAX_LEN:
  - o_pkt_len <= [11:0]; o_hdr_vld pulse; remaining <= len; go to SAMPLES.
- WAIT_HDR, any other good word: hdr_err_cnt +1, stay in WAIT_HDR.
- SAMPLES, good word: o_data <= word; o_vld pulse; remaining -1.
  - When remaining was 1: o_pkt_done pulses with o_vld; go to WAIT_HDR.
- SAMPLES, framing error: abort the packet; go to WAIT_HDR; o_pkt_done not asserted.
- A dropped parity word in SAMPLES is not counted toward remaining.
- o_in_pkt = (state == SAMPLES).

Counters and data:
- Increments saturate at 8'hFF.
- i_clr_cnt has priority over an increment in the same cycle; result 0.
- o_data holds its value between strobes.
- No backpressure: the downstream stage must accept one word per o_vld.

Reset mid-word or mid-packet: immediate return to reset state; the partial word is lost; no strobe is emitted.

Optional Feature:
- RCV_PARITY_EN defined: L = WORD_W+1, parity checked, par_err_cnt live.
- RCV_PARITY_EN not defined: L = WORD_W, no parity bit, o_par_err_cnt tied to 0, every complete word is good.

Decomposition:
- Package rcv_link_pkg holds:
  - word FSM enum {HUNT, SHIFT};
  - packet FSM enum {WAIT_HDR, SAMPLES};
  - HDR_TAG default;
  - field positions (TAG_MSB=15, TAG_LSB=12, LEN_MSB=11);
  - function sat_inc8.
- One sub-module, rcv_word_shifter: the word FSM, shift register, bit counter, parity check and early-sync detection. It outputs word, word_ok, word_par_err and word_frm_err.
- The top level holds the packet FSM and the counters.

Test Plan:
- Header 16'hA003, then samples 16'h0011, 16'h0022, 16'h0033, back-to-back, parity on:
  - o_hdr_vld 1 cycle after the header's last bit; o_pkt_len=3;
  - three o_vld with those values; o_pkt_done with 16'h0033; o_in_pkt falls after it.
- Header 16'hA002; first sample sent with a flipped parity bit, then 16'h0101 and 16'h0202:
  - par_err_cnt=1; o_vld for 16'h0101 and 16'h0202; o_pkt_done with 16'h0202.
- i_fs pulsed at bit 7 of a sample word inside a packet:
  - frm_err_cnt=1; packet aborted; no o_pkt_done; the next word is parsed as a header.
- Headers 16'h5003 and 16'hA000 in WAIT_HDR:
  - hdr_err_cnt=2; no o_hdr_vld; o_in_pkt stays 0.
- 300 consecutive bad headers:
  - hdr_err_cnt saturates at 255.
  - i_clr_cnt pulsed on a cycle that also has a bad header: count reads 0 on the next cycle.
- rst_n asserted mid-packet after 1 of 3 samples:
  - all outputs 0; then a fresh 16'hA001 + 16'h03FF yields o_vld with 16'h03FF and o_pkt_done.
  - Repeat with RCV_PARITY_EN undefined using 16-bit words: same results, o_par_err_cnt=0.
